truth_table_checker: RTL and testbench

- Response side of the exhaustive combinational gate test flow: receives (input vector, observed output) pairs from a stimulus source and checks each against a parameterised expected truth table.
- Tracks which vectors have been covered, counts mismatches, captures the first failing vector, and signals pass or fail once every vector has been seen.
- Sits between the stimulus sequencer / DUT pair and the grading logic or report.

---
 rtl/truth_table_checker.sv | 87 ++++++++
 tb/tb_truth_table_checker.sv | 137 +++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker: checks (vector, output) pairs against an expected truth table and grades the run
module truth_table_checker #(
  parameter int N_IN = 3,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'b1000_0000,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              vec_valid,
  input  logic [N_IN-1:0]   vec_in,
  input  logic              y_in,
  output logic              vec_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic [2**N_IN-1:0] coverage
);
  localparam int NV = 2**N_IN;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [NV-1:0] cov_q, cov_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic ffv_q, ffv_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;
  logic ready_q, busy_q, done_q, pass_q;
  logic acc, mis;
  always_comb begin
    state_d = state_q;
    cov_d = cov_q;
    err_d = err_q;
    ffv_d = ffv_q;
    ffvec_d = ffvec_q;
    acc = (state_q == RUN) && vec_valid;
    // case inequality so an X/Z observation is graded as a failure
    mis = y_in !== EXPECTED[vec_in];
    if (state_q != RUN && start) begin
      state_d = RUN;
      cov_d = '0;
      err_d = '0;
      ffv_d = 1'b0;
      ffvec_d = '0;
    end else if (acc) begin
      cov_d = cov_q | (NV'(1) << vec_in);
      if (mis) begin
        err_d = (&err_q) ? err_q : err_q + CNT_W'(1);
        ffv_d = 1'b1;
        ffvec_d = ffv_q ? ffvec_q : vec_in;
      end
      state_d = (&cov_d) ? DONE : RUN;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cov_q <= '0;
      err_q <= '0;
      ffv_q <= 1'b0;
      ffvec_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cov_q <= cov_d;
      err_q <= err_d;
      ffv_q <= ffv_d;
      ffvec_q <= ffvec_d;
      ready_q <= state_d == RUN;
      busy_q <= state_d == RUN;
      done_q <= state_d == DONE;
      pass_q <= (state_d == DONE) && (err_d == '0);
    end
  end
  assign vec_ready = ready_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_count = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec = ffvec_q;
  assign coverage = cov_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: default-width and 2-bit-counter checkers on shared stimulus vs a behavioural model
module tb_truth_table_checker;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, vec_valid = 1'b0, y_in = 1'b0;
  logic [2:0] vec_in = '0;
  logic rdy, bsy, dn, ps, ffv;
  logic [7:0] ec;
  logic [2:0] ffvec;
  logic [7:0] cov;
  logic rdy2, bsy2, dn2, ps2, ffv2;
  logic [1:0] ec2;
  logic [2:0] ffvec2;
  logic [7:0] cov2;
  int checks = 0, passes = 0;

  truth_table_checker dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_in(vec_in), .y_in(y_in),
    .vec_ready(rdy), .busy(bsy), .done(dn), .pass(ps), .err_count(ec),
    .first_fail_valid(ffv), .first_fail_vec(ffvec), .coverage(cov));

  truth_table_checker #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_in(vec_in), .y_in(y_in),
    .vec_ready(rdy2), .busy(bsy2), .done(dn2), .pass(ps2), .err_count(ec2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2), .coverage(cov2));

  always #5 clk = ~clk;

  // model: a run is open between start and full coverage; errors counted unbounded, clipped when compared
  bit m_run = 0, m_done = 0, m_ffv = 0;
  int m_err = 0;
  logic [2:0] m_ffvec = '0;
  logic [7:0] m_cov = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_done <= 0; m_err <= 0; m_ffv <= 0; m_ffvec <= '0; m_cov <= '0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1; m_done <= 0; m_err <= 0; m_ffv <= 0; m_ffvec <= '0; m_cov <= '0;
      end
    end else if (vec_valid) begin
      if (y_in !== (&vec_in)) begin
        m_err <= m_err + 1;
        if (!m_ffv) begin m_ffv <= 1; m_ffvec <= vec_in; end
      end
      m_cov[vec_in] <= 1'b1;
      if ((m_cov | (8'd1 << vec_in)) == 8'hFF) begin m_run <= 0; m_done <= 1; end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("model_full", {rdy, bsy, dn, ps, ec, ffv, ffvec, cov},
        {m_run, m_run, m_done, m_done && m_err == 0, 8'((m_err > 255) ? 255 : m_err), m_ffv, m_ffvec, m_cov});
    chk("model_sat", {rdy2, bsy2, dn2, ps2, ec2, ffv2, ffvec2, cov2},
        {m_run, m_run, m_done, m_done && m_err == 0, 2'((m_err > 3) ? 3 : m_err), m_ffv, m_ffvec, m_cov});
  end

  task automatic cyc(input logic s, input logic v, input logic [2:0] x, input logic y);
    @(negedge clk);
    start = s; vec_valid = v; vec_in = x; y_in = y;
  endtask

  task automatic sweep(input logic [7:0] flip);
    for (int i = 0; i < 8; i++) cyc(0, 1, 3'(i), (i == 7) ^ flip[i]);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_state", {rdy, bsy, dn, ps, ec, ffv, ffvec, cov}, 0);

    cyc(1, 0, 0, 0); sweep(8'h00);
    chk("clean_done", {dn, ps}, 2'b11);
    chk("clean_cov", cov, 8'hFF);
    chk("clean_err", {ec, ffv}, 0);

    cyc(1, 0, 0, 0); sweep(8'b1000_1000);
    chk("two_err", ec, 2);
    chk("two_ff", {ffv, ffvec}, 4'b1_011);
    chk("two_pass", {dn, ps}, 2'b10);

    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    for (int i = 1; i < 8; i++) begin
      cyc(0, 1, 3'(i), i == 7);
      if (i == 1) chk("dup_cov", cov, 8'h01);
      if (i == 7) chk("dup_not_done", dn, 0);
    end
    cyc(0, 0, 0, 0);
    chk("dup_done", {dn, ps, ec}, {2'b11, 8'd0});

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 3'(i % 8), (i < 8) ? (i == 7) : (i % 8 != 7));
    chk("held_stop", {rdy, dn, ec}, {2'b01, 8'd0});
    cyc(1, 1, 3'd0, 1'b1);
    cyc(0, 0, 0, 0);
    chk("restart_clear", {rdy, dn, ec, cov}, {2'b10, 8'd0, 8'd0});
    sweep(8'h00);
    chk("restart_clean", {dn, ps, ffv, ec}, {3'b110, 8'd0});

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 3'(i), i == 3);
    cyc(0, 0, 0, 0);
    chk("pre_rst", {bsy, ec}, {1'b1, 8'd1});
    #2 rst = 1;
    #1 chk("async_rst", {rdy, bsy, dn, ps, ec, ffv, ffvec, cov, rdy2, bsy2, dn2, ps2, ec2, ffv2, ffvec2, cov2}, 0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 3'(i), 1'b1);
    cyc(0, 0, 0, 0);
    chk("idle_ignore", {bsy, ec, cov}, 0);

    cyc(1, 0, 0, 0); sweep(8'hFF);
    chk("inv_err_full", ec, 8);
    chk("inv_err_sat", {ec2, ps2, dn2}, 4'b11_0_1);
    chk("inv_ff", {ffv2, ffvec2}, 4'b1_000);

    for (int n = 0; n < 3000; n++) begin
      logic [2:0] x;
      x = 3'($urandom_range(7));
      cyc($urandom_range(19) == 0, $urandom_range(3) != 0, x, (&x) ^ ($urandom_range(7) == 0));
      if ($urandom_range(299) == 0) begin
        #2 rst = 1;
        @(posedge clk);
        #2 rst = 0;
      end
    end
    cyc(0, 0, 0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
